// File: rtl/asip_pkg.sv
// Shared definitions for the ASIP demux sequencing controller: widths, routing modes, FSM states.
package asip_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned CNT_W  = 8;

    typedef enum logic [1:0] {
        MODE_A     = 2'b00,
        MODE_B     = 2'b01,
        MODE_ALT   = 2'b10,
        MODE_SPLIT = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        ROUTE   = 2'b01,
        DRAIN   = 2'b10,
        DONE_ST = 2'b11
    } state_e;

endpackage

// File: rtl/out_slot.sv
// One-entry valid/ready output register; a load in the same cycle as a drain keeps the slot full.
module out_slot #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_data,
    input  logic         i_ready,
    output logic         o_valid,
    output logic [W-1:0] o_data,
    output logic         o_free_c
);

    logic         r_valid;
    logic [W-1:0] r_data;

    // Data is zeroed whenever the slot empties so the output reads 0 while invalid.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end
    end

    assign o_valid  = r_valid;
    assign o_data   = r_data;
    assign o_free_c = !r_valid || i_ready;

endmodule

// File: rtl/demux_route_ctrl.sv
// Block sequencer for the 1:2 sample demux: steers COUNT samples to unit A or B by routing mode.
module demux_route_ctrl #(
    parameter int unsigned DATA_W = asip_pkg::DATA_W,
    parameter int unsigned CNT_W  = asip_pkg::CNT_W
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              START,
    input  logic [1:0]        MODE,
    input  logic [CNT_W-1:0]  COUNT,
    input  logic              IN_VALID,
    input  logic [DATA_W-1:0] IN_DATA,
    output logic              IN_READY,
    output logic              SEL,
    output logic              OUT_A_VALID,
    output logic [DATA_W-1:0] OUT_A,
    input  logic              OUT_A_READY,
    output logic              OUT_B_VALID,
    output logic [DATA_W-1:0] OUT_B,
    input  logic              OUT_B_READY,
    output logic              BUSY,
    output logic              DONE
);

    import asip_pkg::*;

    state_e           r_state;
    mode_e            r_mode;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] r_idx;
    logic             r_busy;
    logic             r_done;

    logic w_route;
    logic w_sel;
    logic w_free_a;
    logic w_free_b;
    logic w_accept;
    logic w_load_a;
    logic w_load_b;
    logic w_last;

    // Destination of the sample at index r_idx under the latched mode.
    always_comb begin
        w_sel = 1'b0;
        case (r_mode)
            MODE_A:     w_sel = 1'b0;
            MODE_B:     w_sel = 1'b1;
            MODE_ALT:   w_sel = r_idx[0];
            MODE_SPLIT: w_sel = !(r_idx < (r_count >> 1));
            default:    w_sel = 1'b0;
        endcase
    end

    assign w_route  = (r_state == ROUTE);
    assign SEL      = w_route && w_sel;
    assign IN_READY = w_route && (w_sel ? w_free_b : w_free_a);
    assign w_accept = IN_VALID && IN_READY;
    assign w_load_a = w_accept && !w_sel;
    assign w_load_b = w_accept && w_sel;
    assign w_last   = (r_idx == (r_count - CNT_W'(1)));

    // Block FSM; BUSY and DONE are registered alongside the state they decode.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            r_state <= IDLE;
            r_mode  <= MODE_A;
            r_count <= '0;
            r_idx   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (START) begin
                        r_mode  <= mode_e'(MODE);
                        r_count <= COUNT;
                        r_idx   <= '0;
                        if (COUNT == '0) begin
                            r_state <= DONE_ST;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= ROUTE;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                ROUTE: begin
                    if (w_accept) begin
                        r_idx <= r_idx + CNT_W'(1);
                        if (w_last) begin
                            r_state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (!OUT_A_VALID && !OUT_B_VALID) begin
                        r_state <= DONE_ST;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                DONE_ST: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign BUSY = r_busy;
    assign DONE = r_done;

    out_slot #(.W(DATA_W)) u_slot_a (
        .clk      (CLK),
        .rst_n    (RESET),
        .i_load   (w_load_a),
        .i_data   (IN_DATA),
        .i_ready  (OUT_A_READY),
        .o_valid  (OUT_A_VALID),
        .o_data   (OUT_A),
        .o_free_c (w_free_a)
    );

    out_slot #(.W(DATA_W)) u_slot_b (
        .clk      (CLK),
        .rst_n    (RESET),
        .i_load   (w_load_b),
        .i_data   (IN_DATA),
        .i_ready  (OUT_B_READY),
        .o_valid  (OUT_B_VALID),
        .o_data   (OUT_B),
        .o_free_c (w_free_b)
    );

endmodule

// File: tb/tb_demux_route_ctrl.sv
// Directed bench for demux_route_ctrl: routing modes, back-pressure, zero-length blocks, reset.
module tb_demux_route_ctrl;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       START;
    logic [1:0] MODE;
    logic [7:0] COUNT;
    logic       IN_VALID;
    logic [7:0] IN_DATA;
    logic       IN_READY;
    logic       SEL;
    logic       OUT_A_VALID;
    logic [7:0] OUT_A;
    logic       OUT_A_READY;
    logic       OUT_B_VALID;
    logic [7:0] OUT_B;
    logic       OUT_B_READY;
    logic       BUSY;
    logic       DONE;

    int checks   = 0;
    int failures = 0;

    int a_q[$];
    int b_q[$];
    int sel_q[$];
    int a_cyc[$];
    int done_cnt;
    int b_seen;
    int busy_seen;
    int last_cyc;

    always #5 CLK = ~CLK;

    demux_route_ctrl dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .START       (START),
        .MODE        (MODE),
        .COUNT       (COUNT),
        .IN_VALID    (IN_VALID),
        .IN_DATA     (IN_DATA),
        .IN_READY    (IN_READY),
        .SEL         (SEL),
        .OUT_A_VALID (OUT_A_VALID),
        .OUT_A       (OUT_A),
        .OUT_A_READY (OUT_A_READY),
        .OUT_B_VALID (OUT_B_VALID),
        .OUT_B       (OUT_B),
        .OUT_B_READY (OUT_B_READY),
        .BUSY        (BUSY),
        .DONE        (DONE)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic check_seq(input string tag, input int got[$], input int exp[$]);
        check({tag, "_len"}, 32'(got.size()), 32'(exp.size()));
        foreach (exp[i]) begin
            check($sformatf("%s_%0d", tag, i), (i < got.size()) ? 32'(got[i]) : 32'hFFFF_FFFF,
                  32'(exp[i]));
        end
    endtask

    // Start a block, then stream samples until DONE is seen (plus a few idle cycles).
    // Called and returns at a negedge. Mode/count inputs are scrambled after START.
    task automatic run_block(input logic [1:0] mode, input logic [7:0] count, input int d[$],
                             input bit hold_start, input int stall);
        int idx;
        int cyc;
        int post;
        int stall_left;
        a_q.delete(); b_q.delete(); sel_q.delete(); a_cyc.delete();
        done_cnt = 0; b_seen = 0; busy_seen = 0;
        START = 1'b1; MODE = mode; COUNT = count; IN_VALID = 1'b0;
        OUT_A_READY = 1'b1; OUT_B_READY = 1'b1;
        @(negedge CLK);
        idx = 0; cyc = 0; post = 0; stall_left = stall;
        while (post < 3 && cyc < 200) begin
            START       = hold_start && (done_cnt == 0);
            MODE        = ~mode;
            COUNT       = 8'd1;
            IN_VALID    = (idx < d.size());
            IN_DATA     = (idx < d.size()) ? 8'(d[idx]) : 8'd0;
            OUT_A_READY = 1'b1;
            OUT_B_READY = 1'b1;
            if (stall_left > 0 && OUT_A_VALID) begin
                OUT_A_READY = 1'b0;
                stall_left--;
            end
            #1;
            if (!OUT_A_READY) begin
                check("stall_in_ready", 32'(IN_READY), 32'd0);
                check("stall_out_a", 32'(OUT_A), 32'(d[0]));
            end
            if (IN_VALID && IN_READY) begin
                sel_q.push_back(int'(SEL));
                idx++;
            end
            if (OUT_A_VALID && OUT_A_READY) begin
                a_q.push_back(int'(OUT_A));
                a_cyc.push_back(cyc);
            end
            if (OUT_B_VALID && OUT_B_READY) b_q.push_back(int'(OUT_B));
            if (OUT_B_VALID) b_seen = 1;
            if (BUSY) busy_seen = 1;
            if (DONE) done_cnt++;
            if (done_cnt > 0) post++;
            cyc++;
            @(negedge CLK);
        end
        START = 1'b0; IN_VALID = 1'b0; IN_DATA = 8'd0;
        last_cyc = cyc;
        check("block_timeout", 32'(cyc < 200), 32'd1);
    endtask

    initial begin
        RESET = 1'b0; START = 1'b0; MODE = 2'b00; COUNT = 8'd0;
        IN_VALID = 1'b0; IN_DATA = 8'd0; OUT_A_READY = 1'b1; OUT_B_READY = 1'b1;
        repeat (2) @(negedge CLK);
        #1;
        check("reset_outs", 32'({IN_READY, SEL, OUT_A_VALID, OUT_A, OUT_B_VALID, OUT_B, BUSY, DONE}),
              32'd0);
        RESET = 1'b1;
        @(negedge CLK);

        // All to A at full throughput.
        run_block(2'b00, 8'd3, '{10, 20, 30}, 1'b0, 0);
        check_seq("t1_a", a_q, '{10, 20, 30});
        check("t1_b_seen", 32'(b_seen), 32'd0);
        check("t1_done", 32'(done_cnt), 32'd1);
        check("t1_busy", 32'(busy_seen), 32'd1);
        check("t1_consec0", 32'(a_cyc.size() == 3 && a_cyc[1] - a_cyc[0] == 1), 32'd1);
        check("t1_consec1", 32'(a_cyc.size() == 3 && a_cyc[2] - a_cyc[1] == 1), 32'd1);

        // Alternate routing.
        run_block(2'b10, 8'd4, '{1, 2, 3, 4}, 1'b0, 0);
        check_seq("t2_a", a_q, '{1, 3});
        check_seq("t2_b", b_q, '{2, 4});
        check_seq("t2_sel", sel_q, '{0, 1, 0, 1});
        check("t2_done", 32'(done_cnt), 32'd1);

        // Split routing with START held high throughout the block.
        run_block(2'b11, 8'd5, '{5, 6, 7, 8, 9}, 1'b1, 0);
        check_seq("t3_a", a_q, '{5, 6});
        check_seq("t3_b", b_q, '{7, 8, 9});
        check_seq("t3_sel", sel_q, '{0, 0, 1, 1, 1});
        check("t3_done", 32'(done_cnt), 32'd1);

        // Back-pressure on A for four cycles.
        run_block(2'b00, 8'd3, '{40, 50, 60}, 1'b0, 4);
        check_seq("t4_a", a_q, '{40, 50, 60});
        check("t4_b_seen", 32'(b_seen), 32'd0);
        check("t4_done", 32'(done_cnt), 32'd1);

        // Zero-length block.
        START = 1'b1; MODE = 2'b00; COUNT = 8'd0;
        #1;
        check("t5_busy_idle", 32'(BUSY), 32'd0);
        @(negedge CLK);
        START = 1'b0;
        #1;
        check("t5_done", 32'(DONE), 32'd1);
        check("t5_busy", 32'(BUSY), 32'd0);
        @(negedge CLK);
        #1;
        check("t5_done_pulse", 32'(DONE), 32'd0);
        check("t5_busy_after", 32'(BUSY), 32'd0);
        check("t5_in_ready", 32'(IN_READY), 32'd0);
        @(negedge CLK);

        // Reset mid-block with both slots full.
        START = 1'b1; MODE = 2'b10; COUNT = 8'd4;
        OUT_A_READY = 1'b0; OUT_B_READY = 1'b0;
        @(negedge CLK);
        START = 1'b0; IN_VALID = 1'b1; IN_DATA = 8'd77;
        @(negedge CLK);
        IN_DATA = 8'd88;
        @(negedge CLK);
        IN_VALID = 1'b0;
        #1;
        check("t6_full", 32'({OUT_A_VALID, OUT_A, OUT_B_VALID, OUT_B}), {14'd0, 1'b1, 8'd77, 1'b1, 8'd88});
        RESET = 1'b0;
        @(negedge CLK);
        #1;
        check("t6_outs", 32'({IN_READY, SEL, OUT_A_VALID, OUT_A, OUT_B_VALID, OUT_B, BUSY, DONE}),
              32'd0);
        RESET = 1'b1; OUT_A_READY = 1'b1; OUT_B_READY = 1'b1; IN_VALID = 1'b1;
        done_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            #1;
            if (DONE) done_cnt++;
            if (IN_READY) done_cnt += 100;
        end
        check("t6_no_done_idle", 32'(done_cnt), 32'd0);
        IN_VALID = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
